md_issue_ctrl: RTL and testbench

//  Initiator side of the E-stage multiply/divide interface. Takes one MD request at a time from the

---
 rtl/md_issue_ctrl_if.sv | 27 ++
 rtl/md_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_md_issue_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_issue_ctrl_if.sv
// Bundle of the pipeline request/response handshakes and the MDU issue bus.
// slave is the issue controller's view; master is the pipeline/MDU side.
interface md_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  md_sel;
    logic [31:0] md_d1;
    logic [31:0] md_d2;
    logic        md_stall;
    logic [31:0] md_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport slave (
        input  req_valid, req_op, req_a, req_b, md_stall, md_out, rsp_ready,
        output req_ready, md_sel, md_d1, md_d2, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_op, req_a, req_b, md_stall, md_out, rsp_ready,
        input  req_ready, md_sel, md_d1, md_d2, rsp_valid, rsp_data
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issues one multiply/divide op at a time to the MDU, waits out MDU busy
// and returns mfhi/mflo results on a valid/ready response channel.
module md_issue_ctrl #(
    parameter int TIMEOUT = 31
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    md_issue_if.slave bus,
    output logic      err
);
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [5:0] WDOG_LIMIT = 6'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] d1_q, d1_d;
    logic [31:0] d2_q, d2_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        err_q, err_d;
    logic [5:0]  wdog_q, wdog_d;

    function automatic logic is_arith(input logic [3:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

    function automatic logic is_read(input logic [3:0] op);
        return op inside {MD_MFHI, MD_MFLO};
    endfunction

    function automatic logic is_known(input logic [3:0] op);
        return is_arith(op) || is_read(op) || (op inside {MD_MTHI, MD_MTLO});
    endfunction

    function automatic logic [5:0] wdog_inc(input logic [5:0] w);
        return (w == 6'h3F) ? w : w + 6'd1;
    endfunction

    assign bus.req_ready = (state_q == IDLE) && !flush;
    assign bus.md_sel    = sel_q;
    assign bus.md_d1     = d1_q;
    assign bus.md_d2     = d2_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign err           = err_q;

    always_comb begin
        state_d     = state_q;
        sel_d       = MD_NONE;
        d1_d        = d1_q;
        d2_d        = d2_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        case (state_q)
            IDLE: begin
                // Unknown ops are consumed here and never reach the MDU.
                if (bus.req_valid && bus.req_ready) begin
                    d1_d = bus.req_a;
                    d2_d = bus.req_b;
                    if (is_known(bus.req_op)) begin
                        sel_d   = bus.req_op;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (is_arith(sel_q)) begin
                    state_d = WAIT;
                    wdog_d  = 6'd0;
                end else if (is_read(sel_q) && !flush) begin
                    rsp_data_d  = bus.md_out;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // An in-flight MDU op cannot be aborted, so flush is ignored here.
                if (!bus.md_stall) begin
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_inc(wdog_q);
                    if (wdog_d >= WDOG_LIMIT) err_d = 1'b1;
                end
            end
            RESP: begin
                if (flush || bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= MD_NONE;
            d1_q        <= '0;
            d2_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: behavioural MDU, scoreboard of expected read results,
// and directed sequences for reset, issue timing, flush and watchdog behaviour.
`timescale 1ns/1ps
module tb_md_issue_ctrl;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic err;
    logic stall_force;

    md_issue_if bus();

    md_issue_ctrl #(.TIMEOUT(31)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Behavioural MDU: mult 5 busy cycles, div 10, results visible via md_out.
    logic [31:0] hi_m, lo_m;
    int          busy_m;
    logic        start_m;

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return x * y;
    endfunction

    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] x, y, q, r;
        x = a;
        y = b;
        q = x / y;
        r = x % y;
        return {r, q};
    endfunction

    assign start_m      = bus.md_sel inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    assign bus.md_stall = start_m || (busy_m != 0) || stall_force;
    assign bus.md_out   = (bus.md_sel == MD_MFHI) ? hi_m : lo_m;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_m   <= 32'd0;
            lo_m   <= 32'd0;
            busy_m <= 0;
        end else begin
            if (busy_m != 0) busy_m <= busy_m - 1;
            case (bus.md_sel)
                MD_MULT:  begin {hi_m, lo_m} <= smul(bus.md_d1, bus.md_d2); busy_m <= 5; end
                MD_MULTU: begin {hi_m, lo_m} <= {32'd0, bus.md_d1} * {32'd0, bus.md_d2}; busy_m <= 5; end
                MD_DIV: begin
                    if (bus.md_d2 != 32'd0) {hi_m, lo_m} <= sdiv(bus.md_d1, bus.md_d2);
                    busy_m <= 10;
                end
                MD_DIVU: begin
                    if (bus.md_d2 != 32'd0) begin
                        lo_m <= bus.md_d1 / bus.md_d2;
                        hi_m <= bus.md_d1 % bus.md_d2;
                    end
                    busy_m <= 10;
                end
                MD_MTHI: hi_m <= bus.md_d1;
                MD_MTLO: lo_m <= bus.md_d1;
                default: ;
            endcase
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        issue_pend = 1'b0;
    logic [3:0]  exp_sel;
    logic [31:0] exp_d1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Negedge sample point: checks the issue cycle and pops the scoreboard on a response handshake.
    task automatic tick();
        @(negedge clk);
        if (issue_pend) begin
            chk("md_sel", {28'd0, bus.md_sel}, {28'd0, exp_sel});
            if (exp_sel != MD_NONE) chk("md_d1", bus.md_d1, exp_d1);
            issue_pend = 1'b0;
        end
        if (bus.rsp_valid && bus.rsp_ready && !flush) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            else chk("rsp_data", bus.rsp_data, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] rd_exp, input bit push);
        int n;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        n = 0;
        tick();
        while (!bus.req_ready && n < 300) begin
            step();
            tick();
            n++;
        end
        if (!bus.req_ready) chk("req_timeout", {31'd0, bus.req_ready}, 32'd1);
        step();
        bus.req_valid = 1'b0;
        if (push && (op == MD_MFHI || op == MD_MFLO)) exp_q.push_back(rd_exp);
        exp_sel    = (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO})
                     ? op : MD_NONE;
        exp_d1     = a;
        issue_pend = 1'b1;
    endtask

    // Counts cycles with req_ready low, starting from the current cycle.
    task automatic gap(output int n);
        n = 0;
        tick();
        while (!bus.req_ready && n < 100) begin
            n++;
            step();
            tick();
        end
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.req_valid   = 1'b0;
        bus.req_op      = 4'd0;
        bus.req_a       = 32'd0;
        bus.req_b       = 32'd0;
        bus.rsp_ready   = 1'b1;
        reset           = 1'b0;
        flush           = 1'b0;
        stall_force     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_md_sel",    {28'd0, bus.md_sel},    32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data",  bus.rsp_data,           32'd0);
        chk("rst_md_d1",     bus.md_d1,              32'd0);
        chk("rst_err",       {31'd0, err},           32'd0);
        step();

        // Reset in the middle of a mult wait
        send(MD_MULT, 32'd3, 32'd4, 32'd0, 1'b0);
        repeat (3) begin tick(); step(); end
        chk("wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_md_sel",    {28'd0, bus.md_sel},    32'd0);
        chk("arst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        step();
        reset = 1'b1;
        tick();
        chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rel_md_sel",    {28'd0, bus.md_sel},    32'd0);
        chk("rel_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rel_err",       {31'd0, err},           32'd0);
        step();

        // Signed mult, issue spacing, then reads of HI/LO
        send(MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0);
        gap(n);
        chk("mult_gap", 32'(n), 32'd7);
        send(MD_MFHI, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
        send(MD_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b1);

        // Unsigned mult and signed div
        send(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0);
        send(MD_MFHI, 32'd0, 32'd0, 32'h0000_0001, 1'b1);
        send(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
        gap(n);
        chk("div_gap", 32'(n), 32'd12);
        send(MD_MFLO, 32'd0, 32'd0, 32'hFFFF_FFFD, 1'b1);
        send(MD_MFHI, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);

        // Unknown op is accepted and dropped
        send(4'hF, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
        tick();
        chk("unk_req_ready", {31'd0, bus.req_ready}, 32'd1);
        step();

        // mthi then mfhi held off for three cycles
        send(MD_MTHI, 32'h0000_1234, 32'd0, 32'd0, 1'b0);
        bus.rsp_ready = 1'b0;
        send(MD_MFHI, 32'd0, 32'd0, 32'h0000_1234, 1'b1);
        tick();
        step();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_rsp_data",  bus.rsp_data,           32'h0000_1234);
            step();
        end
        bus.rsp_ready = 1'b1;
        tick();
        step();
        tick();
        chk("post_rsp_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post_rsp_valid",     {31'd0, bus.rsp_valid}, 32'd0);
        step();

        // Flush blocks acceptance in IDLE
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = MD_MULT;
        tick();
        chk("flush_idle_ready", {31'd0, bus.req_ready}, 32'd0);
        step();
        tick();
        chk("flush_idle_sel", {28'd0, bus.md_sel}, 32'd0);
        step();
        bus.req_valid = 1'b0;
        flush         = 1'b0;

        // Flush during the ISSUE cycle of mflo
        send(MD_MFLO, 32'd0, 32'd0, 32'd0, 1'b0);
        flush = 1'b1;
        tick();
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_iss_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("flush_iss_req_ready", {31'd0, bus.req_ready}, 32'd1);
            step();
        end

        // Flush together with rsp_ready while in RESP
        bus.rsp_ready = 1'b0;
        send(MD_MFHI, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        step();
        tick();
        chk("resp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        step();
        flush         = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        step();
        flush = 1'b0;
        tick();
        chk("flush_resp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("flush_resp_ready", {31'd0, bus.req_ready}, 32'd1);
        step();

        // Flush during WAIT of divu does not cut the wait short
        send(MD_DIVU, 32'd7, 32'd2, 32'd0, 1'b0);
        tick(); step();
        tick(); step();
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_wait_sel", {28'd0, bus.md_sel}, 32'd0);
            step();
        end
        flush = 1'b0;
        gap(n);
        chk("flush_wait_rest", 32'(n), 32'd7);
        send(MD_MFLO, 32'd0, 32'd0, 32'd3, 1'b1);
        send(MD_MFHI, 32'd0, 32'd0, 32'd1, 1'b1);

        // Watchdog: MDU stays busy for 40 cycles
        send(MD_MULT, 32'd1, 32'd1, 32'd0, 1'b0);
        stall_force = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 31) chk("wdog_err_before", {31'd0, err}, 32'd0);
            if (i == 32) chk("wdog_err_set",    {31'd0, err}, 32'd1);
            step();
        end
        stall_force = 1'b0;
        gap(n);
        chk("wdog_release", 32'(n), 32'd1);
        tick();
        chk("wdog_err_sticky", {31'd0, err},           32'd1);
        chk("wdog_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        tick();
        chk("wdog_err_cleared", {31'd0, err}, 32'd0);
        step();

        repeat (3) begin tick(); step(); end
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
